// File: rtl/alu_mdu_seq.sv
// Execute-stage unit: combinational ALU plus multi-cycle multiply/divide with HI/LO registers.
// Latency: ALU 0 cycles; MULT/DIV commit HI/LO on the Nth edge after the start edge; MTHI/MTLO next edge.
// Backpressure: busy is high while a multiply/divide is in flight; requests seen during busy are dropped.
module alu_mdu_seq #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUOp,
   output logic [WIDTH-1:0] ALU_result,
   output logic             zero,
   output logic             overflow,
   input  logic             md_start,
   input  logic [2:0]       md_op,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   localparam int S    = $clog2(WIDTH);
   localparam int MAXN = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXN + 1);
   localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
   localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

   typedef enum logic {IDLE, BUSY} state_t;

   // ---------------- ALU ----------------
   logic [S-1:0]     shamt;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign shamt = A[S-1:0];
   assign sum   = A + B;
   assign diff  = A - B;

   // Combinational op select; overflow only meaningful for ADD/SUB
   always_comb begin
      ALU_result = '0;
      overflow   = 1'b0;
      case (ALUOp)
         4'd0:  ALU_result = A & B;
         4'd1:  ALU_result = A | B;
         4'd2: begin
            ALU_result = sum;
            overflow   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         4'd3: begin
            ALU_result = diff;
            overflow   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         4'd4:  ALU_result = A ^ B;
         4'd5:  ALU_result = ~(A | B);
         4'd6:  ALU_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         4'd7:  ALU_result = {{(WIDTH-1){1'b0}}, (A < B)};
         4'd8:  ALU_result = B << shamt;
         4'd9:  ALU_result = B >> shamt;
         4'd10: ALU_result = $signed(B) >>> shamt;
         4'd11: ALU_result = B << (WIDTH / 2);
         default: ALU_result = '0;
      endcase
   end

   assign zero = (ALU_result == '0);

   // ---------------- MDU ----------------
   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             load, commit, wr_hi, wr_lo;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;

   // Results are formed combinationally from the latched operands and only
   // committed on the final busy edge, so operand changes after start are harmless.
   logic signed [2*WIDTH-1:0] ax, bx;
   logic [2*WIDTH-1:0]        prod_s, prod_u;
   logic                      neg_a, neg_b, div_zero;
   logic [WIDTH-1:0]          mag_a, mag_b, dsr_s, dsr_u;
   logic [WIDTH-1:0]          q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;
   logic [WIDTH-1:0]          res_hi, res_lo;
   logic                      res_wr;

   assign ax       = {{WIDTH{a_q[WIDTH-1]}}, a_q};
   assign bx       = {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign prod_s   = ax * bx;
   assign prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
   assign neg_a    = a_q[WIDTH-1];
   assign neg_b    = b_q[WIDTH-1];
   assign div_zero = (b_q == '0);
   // Magnitude divide; most-negative / -1 naturally yields most-negative with remainder 0
   assign mag_a    = neg_a ? -a_q : a_q;
   assign mag_b    = neg_b ? -b_q : b_q;
   assign dsr_s    = div_zero ? WIDTH'(1) : mag_b;
   assign dsr_u    = div_zero ? WIDTH'(1) : b_q;
   assign q_mag    = mag_a / dsr_s;
   assign r_mag    = mag_a % dsr_s;
   assign quo_s    = (neg_a ^ neg_b) ? -q_mag : q_mag;
   assign rem_s    = neg_a ? -r_mag : r_mag;
   assign quo_u    = a_q / dsr_u;
   assign rem_u    = a_q % dsr_u;

   // Result select; divide by zero suppresses the HI/LO write
   always_comb begin
      res_hi = '0;
      res_lo = '0;
      res_wr = 1'b1;
      case (op_q)
         2'd0: {res_hi, res_lo} = prod_s;
         2'd1: {res_hi, res_lo} = prod_u;
         2'd2: begin res_hi = rem_s; res_lo = quo_s; res_wr = !div_zero; end
         default: begin res_hi = rem_u; res_lo = quo_u; res_wr = !div_zero; end
      endcase
   end

   // State and countdown register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state logic: accept requests only in IDLE, commit when the count hits 1
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      load     = 1'b0;
      commit   = 1'b0;
      wr_hi    = 1'b0;
      wr_lo    = 1'b0;
      case (state)
         IDLE: begin
            if (md_start) begin
               case (md_op)
                  3'd0, 3'd1: begin load = 1'b1; cnt_nx = MUL_N; state_nx = BUSY; end
                  3'd2, 3'd3: begin load = 1'b1; cnt_nx = DIV_N; state_nx = BUSY; end
                  3'd4: wr_hi = 1'b1;
                  3'd5: wr_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         default: begin
            cnt_nx = cnt - 1'b1;
            if (cnt == CW'(1)) begin
               commit   = 1'b1;
               state_nx = IDLE;
            end
         end
      endcase
   end

   assign busy = (state == BUSY);

   // Operand latch and HI/LO registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
         HI   <= '0;
         LO   <= '0;
      end else begin
         if (load) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= md_op[1:0];
         end
         if (commit && res_wr) begin
            HI <= res_hi;
            LO <= res_lo;
         end else begin
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= A;
         end
      end
   end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Bench for alu_mdu_seq: a 32-bit default instance and a 16-bit single-cycle-MDU instance,
// checked against an arithmetic reference model; MDU completions go through a scoreboard queue.
module tb_alu_mdu_seq;
   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0] a32, b32, r32, hi32, lo32;
   logic [3:0]  op32;
   logic        z32, v32, st32, busy32;
   logic [2:0]  mop32;

   logic [15:0] a16, b16, r16, hi16, lo16;
   logic [3:0]  op16;
   logic        z16, v16, st16, busy16;
   logic [2:0]  mop16;

   alu_mdu_seq dut32 (
      .clk(clk), .rst_n(rst_n), .A(a32), .B(b32), .ALUOp(op32), .ALU_result(r32),
      .zero(z32), .overflow(v32), .md_start(st32), .md_op(mop32), .busy(busy32),
      .HI(hi32), .LO(lo32));

   alu_mdu_seq #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut16 (
      .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .ALUOp(op16), .ALU_result(r16),
      .zero(z16), .overflow(v16), .md_start(st16), .md_op(mop16), .busy(busy16),
      .HI(hi16), .LO(lo16));

   int checks = 0;
   int errors = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [31:0] mh[2];
   logic [31:0] ml[2];
   int muln[2] = '{5, 1};
   int divn[2] = '{10, 1};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mask32(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic longint uval(input int w, input logic [31:0] x);
      logic [31:0] m;
      m = x & mask32(w);
      return longint'({32'b0, m});
   endfunction

   function automatic longint sval(input int w, input logic [31:0] x);
      longint v;
      v = uval(w, x);
      if (x[w-1]) v = v - (longint'(1) << w);
      return v;
   endfunction

   // Reference ALU: plain integer arithmetic on the operand values
   task automatic alu_model(input int w, input int op, input logic [31:0] a, b,
                            output logic [31:0] res, output logic ovf);
      longint ua, ub, sa, sb, t, smax, smin;
      logic [63:0] tv;
      int sh;
      ua = uval(w, a); ub = uval(w, b); sa = sval(w, a); sb = sval(w, b);
      smax = (longint'(1) << (w - 1)) - 1;
      smin = -(longint'(1) << (w - 1));
      sh = int'(ua % longint'(w));
      ovf = 1'b0;
      case (op)
         0: t = ua & ub;
         1: t = ua | ub;
         2: begin t = sa + sb; ovf = (t > smax) || (t < smin); end
         3: begin t = sa - sb; ovf = (t > smax) || (t < smin); end
         4: t = ua ^ ub;
         5: t = ~(ua | ub);
         6: t = (sa < sb) ? 1 : 0;
         7: t = (ua < ub) ? 1 : 0;
         8: t = ub << sh;
         9: t = ub >> sh;
         10: t = sb >>> sh;
         11: t = ub << (w / 2);
         default: t = 0;
      endcase
      tv = t;
      res = tv[31:0] & mask32(w);
   endtask

   // Reference MDU: wide products, truncating integer division, modulus follows dividend
   task automatic md_model(input int w, input int op, input logic [31:0] a, b, hin, lin,
                           output logic [31:0] hout, output logic [31:0] lout);
      longint ua, ub, sa, sb, q, r;
      logic [63:0] p;
      ua = uval(w, a); ub = uval(w, b); sa = sval(w, a); sb = sval(w, b);
      hout = hin; lout = lin;
      case (op)
         0, 1: begin
            p = (op == 0) ? 64'(sa * sb) : 64'(ua * ub);
            hout = 32'(p >> w) & mask32(w);
            lout = p[31:0] & mask32(w);
         end
         2, 3: begin
            if (ub != 0) begin
               if (op == 2) begin q = sa / sb; r = sa % sb; end
               else begin q = ua / ub; r = ua % ub; end
               p = q; lout = p[31:0] & mask32(w);
               p = r; hout = p[31:0] & mask32(w);
            end
         end
         4: hout = a & mask32(w);
         5: lout = a & mask32(w);
         default: ;
      endcase
   endtask

   function automatic logic [31:0] hi_of(input int d);
      return (d == 0) ? hi32 : {16'b0, hi16};
   endfunction
   function automatic logic [31:0] lo_of(input int d);
      return (d == 0) ? lo32 : {16'b0, lo16};
   endfunction
   function automatic logic busy_of(input int d);
      return (d == 0) ? busy32 : busy16;
   endfunction

   task automatic alu_chk(input int d, input int op, input logic [31:0] a, b);
      logic [31:0] er, ar;
      logic eo, ao, az;
      int w;
      w = (d == 0) ? 32 : 16;
      if (d == 0) begin a32 = a; b32 = b; op32 = 4'(op); end
      else begin a16 = a[15:0]; b16 = b[15:0]; op16 = 4'(op); end
      #1;
      ar = (d == 0) ? r32 : {16'b0, r16};
      ao = (d == 0) ? v32 : v16;
      az = (d == 0) ? z32 : z16;
      alu_model(w, op, a, b, er, eo);
      chk($sformatf("alu%0d_op%0d_res", w, op), ar, er);
      chk($sformatf("alu%0d_op%0d_ovf", w, op), ao, eo);
      chk($sformatf("alu%0d_op%0d_zero", w, op), az, er == 0);
   endtask

   // Drive one md_start pulse; when the bench expects acceptance, update the model
   task automatic issue(input int d, input int op, input logic [31:0] a, b, input bit accept);
      logic [31:0] nh, nl;
      exp_t e;
      int w;
      w = (d == 0) ? 32 : 16;
      @(negedge clk);
      if (d == 0) begin a32 = a; b32 = b; mop32 = 3'(op); st32 = 1'b1; end
      else begin a16 = a[15:0]; b16 = b[15:0]; mop16 = 3'(op); st16 = 1'b1; end
      @(posedge clk);
      #1;
      st32 = 1'b0; st16 = 1'b0;
      if (accept) begin
         md_model(w, op, a, b, mh[d], ml[d], nh, nl);
         if (op <= 3) begin
            e.hi = nh; e.lo = nl;
            e.n = (op >= 2) ? divn[d] : muln[d];
            if (d == 0) q0.push_back(e); else q1.push_back(e);
         end else begin
            chk($sformatf("mt%0d_op%0d_hi", w, op), hi_of(d), nh);
            chk($sformatf("mt%0d_op%0d_lo", w, op), lo_of(d), nl);
            chk($sformatf("mt%0d_op%0d_busy", w, op), busy_of(d), 1'b0);
         end
         mh[d] = nh; ml[d] = nl;
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: on each busy falling edge, pop the expected result and compare, including busy length
   int  bcnt[2];
   bit  prevb[2];
   exp_t me;
   always @(negedge clk) begin
      if (!rst_n) begin
         bcnt[0] = 0; bcnt[1] = 0; prevb[0] = 1'b0; prevb[1] = 1'b0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (busy_of(d)) bcnt[d]++;
            else if (prevb[d]) begin
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  checks++; errors++;
                  $display("FAIL sb_unexpected_commit dut%0d: got commit expected none at %0t", d, $time);
               end else begin
                  me = (d == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("sb%0d_hi", d), hi_of(d), me.hi);
                  chk($sformatf("sb%0d_lo", d), lo_of(d), me.lo);
                  chk($sformatf("sb%0d_busy_len", d), 64'(bcnt[d]), 64'(me.n));
               end
               bcnt[d] = 0;
            end
            prevb[d] = busy_of(d);
         end
      end
   end

   initial begin
      logic [31:0] ra, rb;
      int rop;
      rst_n = 1'b0;
      a32 = '0; b32 = '0; op32 = '0; st32 = 1'b0; mop32 = '0;
      a16 = '0; b16 = '0; op16 = '0; st16 = 1'b0; mop16 = '0;
      mh = '{0, 0}; ml = '{0, 0};
      wait_cycles(2);
      chk("rst_busy32", busy32, 1'b0);
      chk("rst_hi32", hi32, 32'h0);
      chk("rst_lo32", lo32, 32'h0);
      chk("rst_busy16", busy16, 1'b0);
      chk("rst_hilo16", {hi16, lo16}, 32'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Directed ALU cases with literal expectations
      a32 = 32'h7FFF_FFFF; b32 = 32'h1; op32 = 4'd2; #1;
      chk("add_ovf_res", r32, 32'h8000_0000); chk("add_ovf_flag", v32, 1'b1);
      a32 = 32'd5; b32 = 32'd5; op32 = 4'd3; #1;
      chk("sub_zero_res", r32, 32'h0); chk("sub_zero_flag", z32, 1'b1);
      a32 = 32'hFFFF_FFFF; b32 = 32'h1; op32 = 4'd6; #1;
      chk("slt_neg", r32, 32'h1);
      op32 = 4'd7; #1;
      chk("sltu_big", r32, 32'h0);
      a32 = 32'd4; b32 = 32'h8000_0000; op32 = 4'd10; #1;
      chk("sra_sign", r32, 32'hF800_0000);

      // Randomised ALU sweep on both widths
      for (int i = 0; i < 48; i++) begin
         ra = $urandom; rb = $urandom;
         if (i % 4 == 0) ra = 32'(i % 40);
         alu_chk(i % 2, i % 16, ra, rb);
      end
      alu_chk(1, 2, 32'h7FFF, 32'h0001);
      alu_chk(1, 3, 32'h8000, 32'h0001);

      // Multiply/divide at 32 bits
      issue(0, 0, -32'sd3, 32'd7, 1); wait_cycles(5);
      chk("mult_hi", hi32, 32'hFFFF_FFFF); chk("mult_lo", lo32, 32'hFFFF_FFEB);
      issue(0, 1, 32'hFFFF_FFFF, 32'd2, 1); wait_cycles(5);
      chk("multu_hi", hi32, 32'h1); chk("multu_lo", lo32, 32'hFFFF_FFFE);
      issue(0, 2, -32'sd7, 32'd2, 1); wait_cycles(10);
      chk("div_lo", lo32, 32'hFFFF_FFFD); chk("div_hi", hi32, 32'hFFFF_FFFF);
      issue(0, 2, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_cycles(10);
      chk("divovf_lo", lo32, 32'h8000_0000); chk("divovf_hi", hi32, 32'h0);
      issue(0, 4, 32'h11, 32'h0, 1);
      issue(0, 5, 32'h22, 32'h0, 1);
      issue(0, 3, 32'd99, 32'h0, 1); wait_cycles(10);
      chk("div0_hi", hi32, 32'h11); chk("div0_lo", lo32, 32'h22);

      // Requests while busy are dropped; a start right as busy falls is accepted
      issue(0, 0, 32'd100, 32'd3, 1);
      issue(0, 4, 32'h55, 32'h0, 0);
      issue(0, 0, 32'd9, 32'd9, 0);
      wait_cycles(3);
      chk("busy_ign_hi", hi32, 32'h0); chk("busy_ign_lo", lo32, 32'd300);
      issue(0, 1, 32'd6, 32'd7, 1); wait_cycles(5);
      chk("b2b_lo", lo32, 32'd42);

      issue(0, 5, 32'hAB, 32'h0, 1);
      wait_cycles(2);
      chk("mtlo_lo", lo32, 32'hAB);

      // 16-bit instance with one-cycle MDU
      issue(1, 0, -32'sd3, 32'd7, 1); wait_cycles(1);
      chk("mult16", {hi16, lo16}, 32'hFFFF_FFEB);
      issue(1, 1, 32'hFFFF, 32'd2, 1); wait_cycles(1);
      issue(1, 2, -32'sd7, 32'd2, 1); wait_cycles(1);
      chk("div16", {hi16, lo16}, 32'hFFFF_FFFD);
      issue(1, 2, 32'h8000, 32'hFFFF, 1); wait_cycles(1);
      issue(1, 3, 32'h1234, 32'h0, 1); wait_cycles(1);

      // Randomised MDU traffic on both instances
      for (int i = 0; i < 40; i++) begin
         int d;
         d = i % 2;
         rop = $urandom_range(0, 7);
         ra = $urandom; rb = $urandom;
         if (i % 5 == 0) rb = 32'(i % 3);
         if (i % 7 == 0) ra = -ra;
         issue(d, rop, ra, rb, 1);
         if (rop <= 3) wait_cycles((rop >= 2) ? divn[d] : muln[d]);
         else begin
            chk("md_idle_hi", hi_of(d), mh[d]);
            chk("md_idle_lo", lo_of(d), ml[d]);
         end
      end
      wait_cycles(2);

      // Reset in the middle of a divide: immediate clear, no late commit
      issue(0, 2, 32'd100, 32'd7, 1);
      wait_cycles(6);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy32, 1'b0);
      chk("midrst_hi", hi32, 32'h0);
      chk("midrst_lo", lo32, 32'h0);
      q0.delete();
      mh = '{0, 0}; ml = '{0, 0};
      @(negedge clk);
      #1 rst_n = 1'b1;
      wait_cycles(15);
      chk("postrst_busy", busy32, 1'b0);
      chk("postrst_hi", hi32, 32'h0);
      chk("postrst_lo", lo32, 32'h0);

      wait_cycles(3);
      chk("sb0_drained", 64'(q0.size()), 64'd0);
      chk("sb1_drained", 64'(q1.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
